// File: rtl/arb_pkg.sv
// Shared types and helpers for the weighted round-robin arbitration layer.
// Helpers work on fixed maximum-width vectors; callers zero-extend with the
// package types and truncate results back to their own widths.
package arb_pkg;

  // Upper bounds for the generic helpers; instantiations are range-checked.
  localparam int ARB_MAX_CLIENTS = 64;
  localparam int ARB_MAX_WW      = 8;
  localparam int ARB_IDX_W       = 6;

  typedef logic [ARB_MAX_CLIENTS-1:0]            arb_vec_t;
  typedef logic [ARB_MAX_CLIENTS*ARB_MAX_WW-1:0] arb_wflat_t;
  typedef logic [ARB_MAX_WW-1:0]                 arb_w_t;
  typedef logic [ARB_IDX_W-1:0]                  arb_idx_t;

  typedef struct packed {
    logic     found;
    arb_idx_t idx;
  } arb_pick_t;

  typedef enum logic {
    ARB_IDLE,
    ARB_OWN
  } arb_state_e;

  // Weight of client idx from a flat vector of ww-bit fields.
  function automatic arb_w_t weight_of(input arb_wflat_t flat, input int idx, input int ww);
    arb_w_t w;
    arb_w_t mask;
    w    = arb_w_t'(flat >> (idx * ww));
    mask = arb_w_t'((1 << ww) - 1);
    return w & mask;
  endfunction

  // First set bit of req[n-1:0] scanning ptr, ptr+1, ... with wraparound.
  // The vector is rotated so that ptr lands at bit 0; the lowest set bit of
  // the rotated vector is then the winner, mapped back to a real index.
  function automatic arb_pick_t rr_find_first(input arb_vec_t req, input int ptr, input int n);
    arb_vec_t  nmask;
    arb_vec_t  v;
    arb_vec_t  rot;
    arb_pick_t res;
    int        j;
    nmask = (n >= ARB_MAX_CLIENTS) ? '1 : ((arb_vec_t'(1) << n) - arb_vec_t'(1));
    v     = req & nmask;
    rot   = ((v >> ptr) | (v << (n - ptr))) & nmask;
    res   = '0;
    // Descending loop so the lowest rotated position is the last to write.
    for (int k = ARB_MAX_CLIENTS - 1; k >= 0; k--) begin
      if (rot[k]) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        res.found = 1'b1;
        res.idx   = arb_idx_t'(j);
      end
    end
    return res;
  endfunction

  // Index of the set bit of a one-hot vector; 0 for an all-zero vector.
  function automatic arb_idx_t onehot_to_index(input arb_vec_t vec);
    arb_idx_t idx;
    idx = '0;
    for (int k = 0; k < ARB_MAX_CLIENTS; k++) begin
      if (vec[k]) idx = idx | arb_idx_t'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating-priority picker: first requester at or after pointer, with wrap.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Ports: request (per-client level), pointer (scan start) ->
//        pick (one-hot), pick_id (encoded), found (any requester).
module rr_priority_pick
  import arb_pkg::*;
#(
  parameter int CLIENTS = 32,
  parameter int ID_W    = $clog2(CLIENTS)
) (
  input  logic [CLIENTS-1:0] request,
  input  logic [ID_W-1:0]    pointer,
  output logic [CLIENTS-1:0] pick,
  output logic [ID_W-1:0]    pick_id,
  output logic               found
);

  arb_pick_t res;

  always_comb begin
    res     = rr_find_first(arb_vec_t'(request), int'(pointer), CLIENTS);
    found   = res.found;
    pick_id = ID_W'(res.idx);
    pick    = res.found ? (CLIENTS'(1) << pick_id) : '0;
  end

endmodule

// File: rtl/weighted_rr_arbiter.sv
// Weighted round-robin arbiter: an owner holds the grant for up to
// max(weight,1) beats, then priority rotates to the client after it.
// Latency: grant registered, one cycle after request. stall freezes all state.
// Ports: clock, reset_n (async, active-low); request, weight (flat,
//        client i at [i*WEIGHT_W +: WEIGHT_W]), stall ->
//        grant (one-hot/zero), grant_valid, grant_id, burst_last.
module weighted_rr_arbiter
  import arb_pkg::*;
#(
  parameter int CLIENTS  = 32,
  parameter int WEIGHT_W = 4,
  parameter int ID_W     = $clog2(CLIENTS)
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic [CLIENTS-1:0]            request,
  input  logic [CLIENTS*WEIGHT_W-1:0]   weight,
  input  logic                          stall,
  output logic [CLIENTS-1:0]            grant,
  output logic                          grant_valid,
  output logic [ID_W-1:0]               grant_id,
  output logic                          burst_last
);

  if (CLIENTS < 2 || CLIENTS > ARB_MAX_CLIENTS || WEIGHT_W < 1 || WEIGHT_W > ARB_MAX_WW) begin : g_bad_cfg
    $error("weighted_rr_arbiter: CLIENTS or WEIGHT_W outside supported range");
  end

  arb_state_e          state_q, state_d;
  logic [CLIENTS-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] count_q, count_d;

  logic [ID_W-1:0]     owner_id;
  logic [ID_W-1:0]     after_owner;
  logic [ID_W-1:0]     scan_ptr;
  logic [CLIENTS-1:0]  pick;
  logic [ID_W-1:0]     pick_id;
  logic                found;
  logic                owner_req;
  arb_w_t              w_raw;
  logic [WEIGHT_W-1:0] load_cnt;

  // Owner is implied by the registered one-hot grant; no separate register.
  assign owner_id    = ID_W'(onehot_to_index(arb_vec_t'(grant_q)));
  assign after_owner = (owner_id == ID_W'(CLIENTS - 1)) ? '0 : owner_id + 1'b1;
  assign owner_req   = |(grant_q & request);

  // While owning, the only pick that matters is the release reselect, which
  // scans from owner+1 so the old owner comes last (sole-requester re-grant).
  assign scan_ptr = (state_q == ARB_OWN) ? after_owner : ptr_q;

  rr_priority_pick #(
    .CLIENTS (CLIENTS),
    .ID_W    (ID_W)
  ) u_pick (
    .request (request),
    .pointer (scan_ptr),
    .pick    (pick),
    .pick_id (pick_id),
    .found   (found)
  );

  // Weight 0 is treated as a single beat.
  assign w_raw    = weight_of(arb_wflat_t'(weight), int'(pick_id), WEIGHT_W);
  assign load_cnt = (w_raw == '0) ? WEIGHT_W'(1) : WEIGHT_W'(w_raw);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    if (!stall) begin
      case (state_q)
        ARB_IDLE: begin
          if (found) begin
            grant_d = pick;
            count_d = load_cnt;
            state_d = ARB_OWN;
          end
        end
        ARB_OWN: begin
          if (owner_req && count_q > WEIGHT_W'(1)) begin
            count_d = count_q - WEIGHT_W'(1);
          end else begin
            // Final beat or owner dropped its request: rotate and reselect.
            ptr_d = after_owner;
            if (found) begin
              grant_d = pick;
              count_d = load_cnt;
            end else begin
              grant_d = '0;
              count_d = '0;
              state_d = ARB_IDLE;
            end
          end
        end
        default: begin
          grant_d = '0;
          count_d = '0;
          state_d = ARB_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
    end
  end

  assign grant       = grant_q;
  assign grant_valid = |grant_q;
  assign grant_id    = owner_id;
  assign burst_last  = grant_valid && (count_q == WEIGHT_W'(1));

endmodule

// File: doc/weighted_rr_arbiter.md
Name: weighted_rr_arbiter

Overview:
- Parametrised successor to the single-grant round-robin arbiter, for the same arbitration layer of the design.
- Adds per-client programmable weights: a granted client may hold the grant for up to weight service beats before priority rotates.
- Adds a registered one-hot grant plus an encoded grant index, a burst-last flag, and a stall input that freezes all arbitration state.
- Provides a provable bounded-wait guarantee for the formal bench.

Parameters:
- CLIENTS, 32, number of requesters (>=2).
- WEIGHT_W, 4, bits per client weight.
- ID_W, $clog2(CLIENTS), width of the encoded grant index (derived; do not override).

Ports:
- clock  input  1  sole clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- request  input  CLIENTS  per-client request level.
- weight  input  CLIENTS*WEIGHT_W  flat weights; client i uses bits [i*WEIGHT_W +: WEIGHT_W].
- stall  input  1  freezes all arbitration state while high.
- grant  output  CLIENTS  registered grant, one-hot or zero.
- grant_valid  output  1  equals |grant.
- grant_id  output  ID_W  index of the granted client; 0 when grant_valid=0.
- burst_last  output  1  high while the current grant cycle is the owner's final allowed beat.

Behaviour:
- Reset (async assert, sync deassert externally): grant=0, grant_valid=0, grant_id=0, burst_last=0, pointer=0, count=0, state=IDLE.
- State: IDLE (no owner) or OWN (owner index, remaining count, rotating pointer).
- Beat: a cycle with grant[i]=1, request[i]=1 and stall=0. Count decrements by 1 per beat.
- Selection: first requesting client scanning pointer, pointer+1, … with wraparound mod CLIENTS.
  - New owner's count loads max(weight[i],1); weight 0 behaves as 1.
  - Weight is sampled only at load; later changes do not affect the current burst.
- IDLE with stall=0 and |request: select a client; grant is registered, so it appears next cycle (latency 1 from request). Go to OWN.
- IDLE with no request, or with stall=1: remain idle with grant=0.
- OWN, beat with count>1: keep the owner, count-1, grant unchanged.
- OWN, release: on a beat with count==1, or a cycle with grant[i]=1, request[i]=0 and stall=0.
  - pointer <= owner+1 (wraps CLIENTS-1 to 0).
  - Reselect in the same cycle with the scan starting at owner+1, so a back-to-back grant has no bubble.
  - The old owner is re-grantable only if it is the sole requester.
  - If no other request is present, go to IDLE and grant=0 next cycle.
- stall=1: pointer, count, owner and grant outputs hold their values. No beat or release occurs. Request changes during stall are ignored until stall drops.
- burst_last = grant_valid & (count==1), registered consistently with grant.
- grant is never multi-hot.
- grant[i] only rises if request[i] was high in the previous cycle.
- Environment contract: a request stays high until granted. This is the same stability assumption the existing arbiter bench uses.
- Bounded wait: with stall held low and the contract met, request[i] is granted within 1 + Σ_{j≠i} max(weight[j],1) cycles. The default configuration bound is 1+31*15=466.
- Reset mid-burst: outputs clear asynchronously. The first post-reset selection starts from client 0.

Decomposition:
- Package arb_pkg:
  - function to extract the weight of client i from the flat vector;
  - function for the rotating find-first with wraparound;
  - function for one-hot-to-index encoding.
- Sub-module rr_priority_pick (combinational):
  - inputs: request vector, pointer;
  - outputs: one-hot pick, pick index, found flag.
- The top-level FSM and counter stay in weighted_rr_arbiter.

Test Plan:
- CLIENTS=4, all weights=1, request=4'b1111 held, stall=0 → grant cycles 0001,0010,0100,1000,0001 on consecutive cycles; burst_last=1 on every grant cycle.
- Weights {3,1,2,1} (client0..3), request=4'b1111 held → client0 granted 3 cycles, client1 1, client2 2, client3 1, then repeat; burst_last on cycles 3,4,6,7.
- Client2 alone, weight=0, request held for 5 cycles → grant=0100 on cycles 1..5 with re-grant each cycle; grant_id=2.
- Client1 granted with weight=4; request[1] drops after 2 beats while request[3] is high → grant moves to 1000 on the next cycle; pointer=2.
- Stall=1 asserted mid-burst for 3 cycles → grant, grant_id and burst_last are frozen and the count is unchanged; the burst resumes where it left off after stall=0.
- reset_n pulled low during a client3 burst → grant=0 immediately; after release with request=4'b1010, the first grant is client1.
